// File: rtl/l2_req_scheduler.sv
// l2_req_scheduler: arbitrates I-cache and D-cache line misses onto the single L2 request port
module l2_req_scheduler #(
  parameter int WORD_W       = 16,
  parameter int LINE_W       = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] ic_addr,
  input  logic              ic_read,
  input  logic              ic_write,
  input  logic [LINE_W-1:0] ic_wdata,
  input  logic [1:0]        ic_byte_enable,
  output logic              ic_resp,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic [WORD_W-1:0] dc_addr,
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [LINE_W-1:0] dc_wdata,
  input  logic [1:0]        dc_byte_enable,
  output logic              dc_resp,
  output logic [LINE_W-1:0] dc_rdata,
  output logic [WORD_W-1:0] l2_addr,
  output logic              l2_read,
  output logic              l2_write,
  output logic [LINE_W-1:0] l2_wdata,
  output logic [1:0]        l2_byte_enable,
  input  logic              l2_resp,
  input  logic [LINE_W-1:0] l2_rdata
);
  typedef enum logic [1:0] {IDLE, IC_XFER, DC_XFER, DONE} state_t;
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  state_t     r_state, w_state;
  logic [3:0] r_starve, w_starve;
  logic       r_owner_dc, w_owner_dc;
  logic       w_ic_req, w_dc_req, w_ic_grant, w_dc_grant, w_xfer_done;
  assign w_ic_req    = ic_read | ic_write;
  assign w_dc_req    = dc_read | dc_write;
  assign w_xfer_done = (r_state == IC_XFER || r_state == DC_XFER) && l2_resp;
  // state, starvation counter and owner registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_starve   <= '0;
      r_owner_dc <= 1'b1;
    end else begin
      r_state    <= w_state;
      r_starve   <= w_starve;
      r_owner_dc <= w_owner_dc;
    end
  end
  // arbitration and next-state: D-cache wins unless the I-cache has waited out LIM D-cache grants
  always_comb begin
    w_state    = r_state;
    w_starve   = r_starve;
    w_owner_dc = r_owner_dc;
    w_ic_grant = 1'b0;
    w_dc_grant = 1'b0;
    case (r_state)
      IDLE: begin
        w_ic_grant = w_ic_req && (!w_dc_req || r_starve == LIM);
        w_dc_grant = w_dc_req && !w_ic_grant;
        w_state    = w_ic_grant ? IC_XFER : w_dc_grant ? DC_XFER : IDLE;
        w_owner_dc = w_dc_grant ? 1'b1 : w_ic_grant ? 1'b0 : r_owner_dc;
        w_starve   = (w_ic_grant || !w_ic_req) ? 4'd0 : (r_starve == LIM) ? r_starve : r_starve + 4'd1;
      end
      IC_XFER, DC_XFER: w_state = l2_resp ? DONE : r_state;
      default:          w_state = IDLE;
    endcase
  end
  // registered L2 request, response pulses and read-line capture; write wins when both strobes are raised
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l2_addr        <= '0;
      l2_wdata       <= '0;
      l2_byte_enable <= '0;
      l2_read        <= 1'b0;
      l2_write       <= 1'b0;
      ic_resp        <= 1'b0;
      dc_resp        <= 1'b0;
      ic_rdata       <= '0;
      dc_rdata       <= '0;
    end else begin
      if (w_ic_grant || w_dc_grant) begin
        l2_addr        <= w_dc_grant ? dc_addr : ic_addr;
        l2_wdata       <= w_dc_grant ? dc_wdata : ic_wdata;
        l2_byte_enable <= w_dc_grant ? dc_byte_enable : ic_byte_enable;
        l2_write       <= w_dc_grant ? dc_write : ic_write;
        l2_read        <= w_dc_grant ? dc_read & ~dc_write : ic_read & ~ic_write;
      end
      if (w_xfer_done) begin
        l2_read  <= 1'b0;
        l2_write <= 1'b0;
      end
      if (w_xfer_done && l2_read && !r_owner_dc) ic_rdata <= l2_rdata;
      if (w_xfer_done && l2_read && r_owner_dc) dc_rdata <= l2_rdata;
      ic_resp <= w_xfer_done && !r_owner_dc;
      dc_resp <= w_xfer_done && r_owner_dc;
    end
  end
endmodule

// File: tb/tb_l2_req_scheduler.sv
// tb_l2_req_scheduler: randomized and directed checks of the L2 request scheduler against a transaction model
module tb_l2_req_scheduler;
  localparam int WORD_W = 16;
  localparam int LINE_W = 128;
  localparam int LIM    = 4;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [WORD_W-1:0] ic_addr = '0, dc_addr = '0;
  logic              ic_read = 1'b0, ic_write = 1'b0, dc_read = 1'b0, dc_write = 1'b0;
  logic [LINE_W-1:0] ic_wdata = '0, dc_wdata = '0;
  logic [1:0]        ic_byte_enable = '0, dc_byte_enable = '0;
  logic              ic_resp, dc_resp, l2_read, l2_write;
  logic [LINE_W-1:0] ic_rdata, dc_rdata, l2_wdata;
  logic [WORD_W-1:0] l2_addr;
  logic [1:0]        l2_byte_enable;
  logic              l2_resp = 1'b0;
  logic [LINE_W-1:0] l2_rdata = '0;
  int checks = 0, failures = 0;
  // transaction model state
  bit                m_busy, m_done, m_owner_dc, m_wr;
  int                m_starve, m_delay;
  logic [WORD_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata, m_ic_rdata, m_dc_rdata;
  logic [1:0]        m_be;
  logic [31:0]       ordv;
  int                ord_n;
  // stimulus knobs
  int ic_rate = 0, dc_rate = 0, dc_auto = 0, dmin = 1, dmax = 1, rd_cyc, wr_cyc;
  bit scramble = 0, spurious = 1, fix_en = 0;
  logic [LINE_W-1:0] fix_rdata = '0;
  localparam logic [LINE_W-1:0] A5 = {16{8'hA5}};

  always #5 clk = ~clk;

  l2_req_scheduler #(.WORD_W(WORD_W), .LINE_W(LINE_W), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_addr(ic_addr), .ic_read(ic_read), .ic_write(ic_write), .ic_wdata(ic_wdata),
    .ic_byte_enable(ic_byte_enable), .ic_resp(ic_resp), .ic_rdata(ic_rdata),
    .dc_addr(dc_addr), .dc_read(dc_read), .dc_write(dc_write), .dc_wdata(dc_wdata),
    .dc_byte_enable(dc_byte_enable), .dc_resp(dc_resp), .dc_rdata(dc_rdata),
    .l2_addr(l2_addr), .l2_read(l2_read), .l2_write(l2_write), .l2_wdata(l2_wdata),
    .l2_byte_enable(l2_byte_enable), .l2_resp(l2_resp), .l2_rdata(l2_rdata)
  );

  task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [LINE_W-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic new_req(input bit dc, input bit rd, input bit wr, input logic [WORD_W-1:0] a,
                         input logic [LINE_W-1:0] d, input logic [1:0] be);
    if (dc) begin
      dc_read = rd; dc_write = wr; dc_addr = a; dc_wdata = d; dc_byte_enable = be;
    end else begin
      ic_read = rd; ic_write = wr; ic_addr = a; ic_wdata = d; ic_byte_enable = be;
    end
    if (rd && wr) $display("note: protocol error, %s read and write raised together", dc ? "dc" : "ic");
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_strobes"}, {l2_read, l2_write}, 2'b00);
    check({tag, "_resps"}, {ic_resp, dc_resp}, 2'b00);
  endtask

  task automatic check_reset(input string tag);
    check_quiet(tag);
    check({tag, "_addr"}, l2_addr, '0);
    check({tag, "_wdata"}, l2_wdata, '0);
    check({tag, "_be"}, l2_byte_enable, '0);
    check({tag, "_ic_rdata"}, ic_rdata, '0);
    check({tag, "_dc_rdata"}, dc_rdata, '0);
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_starve = 0; m_owner_dc = 1;
    m_ic_rdata = '0; m_dc_rdata = '0;
  endtask

  // one cycle: called just after a falling edge; checks what the last rising edge produced, then drives the next inputs
  task automatic step();
    bit icq, dcq, l2r, w;
    icq = ic_read | ic_write;
    dcq = dc_read | dc_write;
    l2r = l2_resp;
    if (m_done) begin
      m_done = 0;
      m_busy = 0;
      check_quiet("done");
    end else if (!m_busy) begin
      if (icq || dcq) begin
        m_owner_dc = !(icq && (!dcq || m_starve == LIM));
        m_starve   = (m_owner_dc && icq) ? ((m_starve < LIM) ? m_starve + 1 : LIM) : 0;
        m_wr       = m_owner_dc ? dc_write : ic_write;
        m_addr     = m_owner_dc ? dc_addr : ic_addr;
        m_wdata    = m_owner_dc ? dc_wdata : ic_wdata;
        m_be       = m_owner_dc ? dc_byte_enable : ic_byte_enable;
        m_busy     = 1;
        m_delay    = $urandom_range(dmin, dmax);
        ordv       = {ordv[30:0], m_owner_dc};
        ord_n++;
      end else begin
        m_starve = 0;
        check_quiet("idle");
      end
    end else if (l2r) begin
      if (!m_wr && m_owner_dc) m_dc_rdata = l2_rdata;
      if (!m_wr && !m_owner_dc) m_ic_rdata = l2_rdata;
      check("resp_ic", ic_resp, !m_owner_dc);
      check("resp_dc", dc_resp, m_owner_dc);
      check("resp_strobes", {l2_read, l2_write}, 2'b00);
      m_done = 1;
    end
    if (m_busy && !m_done) begin
      check("xfer_read", l2_read, !m_wr);
      check("xfer_write", l2_write, m_wr);
      check("xfer_addr", l2_addr, m_addr);
      check("xfer_wdata", l2_wdata, m_wdata);
      check("xfer_be", l2_byte_enable, m_be);
      check("xfer_resps", {ic_resp, dc_resp}, 2'b00);
    end
    check("ic_rdata", ic_rdata, m_ic_rdata);
    check("dc_rdata", dc_rdata, m_dc_rdata);
    // requesters drop after their pulse and may issue a fresh request the following cycle
    if (m_done && !m_owner_dc) begin
      ic_read = 0; ic_write = 0;
    end else if (!icq && ic_rate > int'($urandom_range(0, 99))) begin
      w = 1'($urandom_range(0, 1));
      new_req(0, !w, w, 16'($urandom), rnd_line(), 2'($urandom));
    end
    if (m_done && m_owner_dc) begin
      dc_read = 0; dc_write = 0;
    end else if (!dcq && dc_auto > 0) begin
      dc_auto--;
      new_req(1, 1, 0, 16'($urandom), rnd_line(), 2'($urandom));
    end else if (!dcq && dc_rate > int'($urandom_range(0, 99))) begin
      w = 1'($urandom_range(0, 1));
      new_req(1, !w, w, 16'($urandom), rnd_line(), 2'($urandom));
    end
    if (scramble && m_busy && !m_done) begin
      if (m_owner_dc) begin dc_wdata = rnd_line(); dc_addr = 16'($urandom); end
      else begin ic_wdata = rnd_line(); ic_addr = 16'($urandom); end
    end
    // L2 responder: single-cycle l2_resp after a random wait, stray pulses while nothing is outstanding
    l2_rdata = fix_en ? fix_rdata : rnd_line();
    l2_resp  = 0;
    if (m_busy && !m_done) begin
      if (m_delay == 0) l2_resp = 1;
      m_delay--;
    end else l2_resp = spurious && ($urandom_range(0, 3) == 0);
  endtask

  task automatic run_quiet(input int budget);
    int n = 0;
    rd_cyc = 0;
    wr_cyc = 0;
    do begin
      @(negedge clk);
      if (l2_read) rd_cyc++;
      if (l2_write) wr_cyc++;
      step();
      n++;
    end while ((m_busy || ic_read || ic_write || dc_read || dc_write) && n < budget);
    check("drain", {m_busy, ic_read | ic_write, dc_read | dc_write}, 3'b000);
  endtask

  initial begin
    model_reset();
    ordv = 0; ord_n = 0;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst_n = 1;
    // IC read alone, L2 answers two cycles into the strobe
    fix_en = 1; fix_rdata = A5; dmin = 1; dmax = 1;
    new_req(0, 1, 0, 16'h1230, '0, 2'b11);
    run_quiet(50);
    check("t1_rd_cycles", rd_cyc, 2);
    check("t1_addr", l2_addr, 16'h1230);
    check("t1_rdata", ic_rdata, A5);
    fix_en = 0;
    // DC write-back with its wdata changing under the strobe
    scramble = 1; dmax = 3;
    new_req(1, 0, 1, 16'h4000, 128'h0123456789ABCDEF0123456789ABCDEF, 2'b11);
    run_quiet(50);
    check("t2_wr_seen", wr_cyc != 0, 1);
    check("t2_wdata", l2_wdata, 128'h0123456789ABCDEF0123456789ABCDEF);
    scramble = 0;
    // simultaneous reads: D first, then I
    ordv = 0; ord_n = 0;
    new_req(0, 1, 0, 16'h0100, '0, 2'b01);
    new_req(1, 1, 0, 16'h0200, '0, 2'b10);
    run_quiet(80);
    check("t3_order", ordv, 32'b10);
    check("t3_count", ord_n, 2);
    // starvation: I held while D issues six back-to-back reads
    ordv = 0; ord_n = 0; dmin = 0; dmax = 2;
    new_req(0, 1, 0, 16'h0300, '0, 2'b11);
    new_req(1, 1, 0, 16'h0400, '0, 2'b11);
    dc_auto = 5;
    run_quiet(400);
    check("t4_order", ordv, 32'b1111011);
    check("t4_count", ord_n, 7);
    // reset in the middle of a DC transaction, stale l2_resp afterwards
    dmin = 20; dmax = 20; spurious = 0;
    new_req(1, 1, 0, 16'h0500, '0, 2'b11);
    for (int i = 0; i < 4; i++) begin @(negedge clk); step(); end
    check("t5_busy", {l2_read, m_busy}, 2'b11);
    @(negedge clk);
    rst_n = 0;
    #1;
    check_reset("t5_reset");
    dc_read = 0; dc_write = 0; l2_resp = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    step();
    l2_resp = 1;
    @(negedge clk);
    step();
    fix_en = 1; fix_rdata = {4{32'hC0DE_F00D}}; dmin = 1; dmax = 1;
    new_req(0, 1, 0, 16'h0600, '0, 2'b11);
    run_quiet(50);
    check("t5_fresh_rdata", ic_rdata, {4{32'hC0DE_F00D}});
    fix_en = 0; spurious = 1;
    // illegal read+write: write wins
    new_req(1, 1, 1, 16'h0700, rnd_line(), 2'b01);
    run_quiet(50);
    check("t6_write", wr_cyc != 0, 1);
    check("t6_read", rd_cyc, 0);
    // random traffic
    dmin = 0; dmax = 3; scramble = 1;
    for (int r = 0; r < 4; r++) begin
      ic_rate = 10 + 25 * r;
      dc_rate = 90 - 20 * r;
      for (int i = 0; i < 1500; i++) begin @(negedge clk); step(); end
    end
    ic_rate = 0; dc_rate = 0;
    run_quiet(200);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/l2_req_scheduler.md
Name: l2_req_scheduler

Overview:
- Sequences line-sized memory transactions from the L1 I-cache and L1 D-cache miss ports onto the single L2 request port.
- Fixed priority favours the D-cache. A starvation counter guarantees forward progress for the I-cache.
- One transaction is outstanding at a time. Address, wdata and byte enable are latched at grant. Read data is registered back to the winning requester with a one-cycle response pulse.
- Sits between the two L1 caches and the L2 cache in the processor top level.

Parameters:
WORD_W, 16, address width (one LC-3b word)
LINE_W, 128, cache line width (8 words)
STARVE_LIMIT, 4, consecutive D-cache grants allowed while an I-cache request waits (1..15)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
ic_addr  input  WORD_W  I-cache line address
ic_read  input  1  I-cache line read request, held until ic_resp
ic_write  input  1  I-cache line write request, held until ic_resp
ic_wdata  input  LINE_W  I-cache write line
ic_byte_enable  input  2  I-cache byte enable
ic_resp  output  1  one-cycle completion pulse to the I-cache
ic_rdata  output  LINE_W  read line for the I-cache
dc_addr  input  WORD_W  D-cache line address
dc_read  input  1  D-cache line read request, held until dc_resp
dc_write  input  1  D-cache write-back request, held until dc_resp
dc_wdata  input  LINE_W  D-cache write-back line
dc_byte_enable  input  2  D-cache byte enable
dc_resp  output  1  one-cycle completion pulse to the D-cache
dc_rdata  output  LINE_W  read line for the D-cache
l2_addr  output  WORD_W  latched address to L2
l2_read  output  1  read strobe to L2
l2_write  output  1  write strobe to L2
l2_wdata  output  LINE_W  latched write line to L2
l2_byte_enable  output  2  latched byte enable to L2
l2_resp  input  1  L2 completion, single cycle
l2_rdata  input  LINE_W  L2 read line, valid with l2_resp

Behaviour:
- FSM states: IDLE, IC_XFER, DC_XFER, DONE.
- All outputs are registered.
- Reset (async, rst_n=0), applied at any time including mid-transaction:
  - state=IDLE, starve_cnt=0, owner=DC.
  - All strobes and resp outputs 0.
  - l2_addr, l2_wdata, l2_byte_enable, ic_rdata, dc_rdata all 0.
  - The in-flight L2 transaction is abandoned. An l2_resp arriving after reset is ignored in IDLE.
- Request from a cache: req = read | write. If read and write are both high, the write is performed. This combination is a protocol error and the bench flags it.
- IDLE arbitration, decided at the clock edge:
  - IC granted if ic_req and (!dc_req or starve_cnt==STARVE_LIMIT).
  - Otherwise DC granted if dc_req.
  - Otherwise remain in IDLE.
- On grant:
  - Latch addr, wdata and byte_enable into the l2_* registers.
  - Set l2_read or l2_write.
  - Go to the corresponding XFER state.
  - Strobes are visible the cycle after the request is first seen in IDLE.
- starve_cnt update at each grant:
  - DC grant while ic_req is high: increment, saturating at STARVE_LIMIT.
  - IC grant: clear to 0.
  - Any IDLE cycle with ic_req low: clear to 0.
- XFER states:
  - Hold all l2_* outputs stable until l2_resp.
  - On l2_resp: drop l2_read/l2_write, capture l2_rdata into the owner's rdata register (reads only; writes leave it unchanged), and go to DONE.
  - No timeout.
- DONE lasts exactly one cycle:
  - Assert the owner's resp for this cycle.
  - L2 strobes are 0.
  - Next state is IDLE.
- Requester obligation: deassert the request in the cycle after the resp pulse. IDLE therefore never re-grants a completed request.
- Latency:
  - Request in IDLE at edge N → L2 strobe high from edge N+1.
  - l2_resp at edge M → owner resp high from edge M+1 to M+2, with rdata valid and held until the next capture.
  - Best case with l2_resp after one cycle: 3 cycles.
- The non-owner's resp is never asserted. Only one resp is high in any cycle.
- l2_resp in IDLE or DONE is ignored.

Test Plan:
- IC read alone, ic_addr=0x1230, L2 responds 2 cycles after l2_read rises with rdata=0xA5..A5 → l2_addr=0x1230, l2_read high 2 cycles, ic_resp 1 cycle with ic_rdata=0xA5..A5, dc_resp stays 0.
- DC write-back alone, dc_addr=0x4000, dc_byte_enable=2'b11, dc_wdata=0x0123..CDEF; dc_wdata changed while l2_write is high → l2_write high with latched data 0x0123..CDEF unchanged, dc_resp pulses, dc_rdata unchanged.
- ic_read and dc_read raised in the same cycle → DC serviced first, then IC granted in the next IDLE. Total two L2 transactions, resp order dc then ic.
- IC read held while the DC issues 6 back-to-back reads (STARVE_LIMIT=4) → grant order DC,DC,DC,DC,IC,DC,DC. starve_cnt returns to 0 after the IC grant.
- rst_n pulled low while in DC_XFER, then l2_resp arrives after rst_n returns high → all outputs 0 immediately, l2_resp ignored, a fresh ic_read is then serviced normally.
- Illegal dc_read and dc_write both high → l2_write asserted, l2_read stays 0.
